ahbl_arbiter: RTL and testbench
===============================

# ahbl_arbiter

Multi-master AHB-Lite arbiter that shares one downstream AHB-Lite slave port (a crossbar source port, or a single slave such as the external SRAM controller) between N_PORTS upstream masters. It lets a second master (display/DMA engine) reach the system bus alongside hazard5_cpu. Losing address phases are captured in per-port buffers and replayed, with the loser stalled through its data phase. Arbitration is fixed-priority: port 0 is highest.

## Interface
- N_PORTS, 2, number of upstream masters
- W_ADDR, 32, address width
- W_DATA, 32, data width

- clk  in  1  system clock; one clock domain
- rst_n  in  1  reset, synchronous, active-low
- src_hready  in  N_PORTS  per-port bus HREADY seen by each master
- src_hready_resp  out  N_PORTS  per-port HREADYOUT
- src_hresp  out  N_PORTS  per-port HRESP
- src_haddr  in  N_PORTS*W_ADDR  per-port HADDR
- src_hwrite, src_htrans, src_hsize, src_hburst, src_hprot, src_hmastlock  in  N_PORTS*{1,2,3,3,4,1}  per-port address-phase controls
- src_hwdata  in  N_PORTS*W_DATA  per-port write data
- src_hrdata  out  N_PORTS*W_DATA  read data, broadcast
- dst_hready  out  1  HREADY to downstream, equal to dst_hready_resp
- dst_hready_resp  in  1  downstream HREADYOUT
- dst_hresp  in  1  downstream HRESP
- dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst, dst_hprot, dst_hmastlock  out  W_ADDR,1,2,3,3,4,1  issued address phase
- dst_hwdata  out  W_DATA  write data of the data-phase owner
- dst_hrdata  in  W_DATA  downstream read data

## Operation
- Port i requests in a cycle if buf_valid[i] is set. It also requests if src_hready[i] & src_htrans[i][1] (live request).
- A port never has a live and a buffered request together, because a buffered port sees src_hready_resp low.
- Grant happens only in cycles with dst_hready_resp=1 and rst_n=1. The lowest-index requesting port wins. The winner's fields (buffer if valid, else live) drive dst_*.
- Issued transfers: dst_htrans=2'b10 (NONSEQ) and dst_hburst=3'b000 (SINGLE) always, because bursts may be interleaved. Other fields pass through unchanged.
- With no grant: dst_htrans=2'b00. Other dst address fields hold the port-0 live values, which are don't-care.
- A live request that is not granted is captured: buf_valid[i] is set and haddr/hwrite/hsize/hprot/hmastlock are latched. This applies to losing a contest and to dst being stalled.
- When a buffered request is granted, buf_valid[i] clears at the next edge.
- Data-phase owner register dp_owner (one-hot, or none). It loads the granted port at each edge where dst_hready_resp=1. It loads none if there was no grant. It holds while dst_hready_resp=0.
- src_hready_resp[i] rules:
  - if dp_owner==i: equals dst_hready_resp
  - else if buf_valid[i]: 0
  - else: 1
- src_hresp[i] = dst_hresp when dp_owner==i, else 0.
- dst_hwdata comes from the dp_owner port, or zero when there is no owner.
- hmastlock is passed through only. It does not affect arbitration; locked sequences are unsupported.
- Fixed priority may starve high-index ports; this is accepted.

## Timing
- Reset, with rst_n sampled low at an edge:
  - buf_valid=0, dp_owner=none.
  - While rst_n is low, dst_htrans=IDLE and no capture occurs.
  - Outputs during reset: src_hready_resp all 1, src_hresp 0, dst_hwdata 0.
- Reset mid-transfer discards buffers and ownership. The whole system resets together, so this is harmless.
- Uncontended live request: zero added latency; the address phase is forwarded in the same cycle.
- Buffered request: issued on the first later cycle where dst_hready_resp=1 and the port has the highest priority. That is at least 1 cycle after capture.
- The loser's data phase completes one dst data phase after issue. The master holds hwdata throughout, because its hready is low.
- Two-cycle ERROR:
  - Cycle 1 (dst_hready_resp=0, dst_hresp=1) goes to the owner only.
  - Cycle 2 (1,1): grants proceed normally. An IDLE/cancelled address from the owner is simply not a request.
- Simultaneous case: a buffered port p and a live port q<p both request on the same ready cycle. q wins; p stays buffered.

## Test plan
- Single master, port 0 reads 0x20080000, zero-wait slave: dst_htrans=NONSEQ in the same cycle. src_hrdata returns one cycle later. No buffering occurs and src_hready_resp[1] stays 1.
- Ports 0 and 1 both NONSEQ in the same cycle (write 0x20000000 data 0xA5A5A5A5; read 0x20000004): port 0 issues first. Port 1 is buffered and sees src_hready_resp[1]=0 for 1 cycle. Port 1 is issued in the next cycle with address 0x20000004. Both complete and the slave sees a correct write.
- Port 1 requests while the slave stalls port 0's data phase for 3 cycles: port 1 is captured and issued on the first dst_hready_resp=1. Its hwdata 0x12345678 reaches the slave.
- Port 0 issues a 4-beat INCR burst and port 1 requests at beat 2: every dst_htrans is NONSEQ and dst_hburst is SINGLE. Port 0 keeps priority and port 1 is served after port 0 goes idle.
- Slave returns a two-cycle ERROR to port 1: src_hresp[1]=1 for both cycles and src_hresp[0]=0. Port 0's concurrent request is buffered, then issued in error cycle 2.
- Assert rst_n low with port 1 buffered: after the edge, buf_valid=0, all src_hready_resp=1 and dst_htrans=IDLE until rst_n is high.

Source files
------------

// File: rtl/ahbl_arbiter_if.sv
// ----------------------------------------------------------------------------
// ahbl_arbiter_if
// Bundles the upstream (src_*, one slice per master) and downstream (dst_*)
// AHB-Lite signals of the fixed-priority arbiter.
//   modport slave  : the arbiter's view (consumes master requests, drives dst)
//   modport master : the environment's view (masters plus downstream slave)
// Per-port buses are packed [N_PORTS-1:0][width-1:0], so slice i is port i.
// ----------------------------------------------------------------------------
interface ahbl_arbiter_if #(
    parameter int N_PORTS = 2,
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32
) ();
    // Upstream, one slice per master
    logic [N_PORTS-1:0]             src_hready;
    logic [N_PORTS-1:0]             src_hready_resp;
    logic [N_PORTS-1:0]             src_hresp;
    logic [N_PORTS-1:0][W_ADDR-1:0] src_haddr;
    logic [N_PORTS-1:0]             src_hwrite;
    logic [N_PORTS-1:0][1:0]        src_htrans;
    logic [N_PORTS-1:0][2:0]        src_hsize;
    logic [N_PORTS-1:0][2:0]        src_hburst;
    logic [N_PORTS-1:0][3:0]        src_hprot;
    logic [N_PORTS-1:0]             src_hmastlock;
    logic [N_PORTS-1:0][W_DATA-1:0] src_hwdata;
    logic [N_PORTS-1:0][W_DATA-1:0] src_hrdata;

    // Downstream
    logic              dst_hready;
    logic              dst_hready_resp;
    logic              dst_hresp;
    logic [W_ADDR-1:0] dst_haddr;
    logic              dst_hwrite;
    logic [1:0]        dst_htrans;
    logic [2:0]        dst_hsize;
    logic [2:0]        dst_hburst;
    logic [3:0]        dst_hprot;
    logic              dst_hmastlock;
    logic [W_DATA-1:0] dst_hwdata;
    logic [W_DATA-1:0] dst_hrdata;

    modport slave (
        input  src_hready, src_haddr, src_hwrite, src_htrans, src_hsize,
               src_hburst, src_hprot, src_hmastlock, src_hwdata,
               dst_hready_resp, dst_hresp, dst_hrdata,
        output src_hready_resp, src_hresp, src_hrdata,
               dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize,
               dst_hburst, dst_hprot, dst_hmastlock, dst_hwdata
    );

    modport master (
        output src_hready, src_haddr, src_hwrite, src_htrans, src_hsize,
               src_hburst, src_hprot, src_hmastlock, src_hwdata,
               dst_hready_resp, dst_hresp, dst_hrdata,
        input  src_hready_resp, src_hresp, src_hrdata,
               dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize,
               dst_hburst, dst_hprot, dst_hmastlock, dst_hwdata
    );
endinterface

// File: rtl/ahbl_arbiter.sv
// ----------------------------------------------------------------------------
// ahbl_arbiter
// Shares one downstream AHB-Lite slave port between N_PORTS masters with
// fixed priority (port 0 highest). A live address phase that cannot be issued
// is captured in a per-port buffer and replayed later; the buffered master is
// held off by a low src_hready_resp. Every issued transfer is NONSEQ/SINGLE
// so bursts from different masters may interleave.
// Ports:
//   clk    : system clock
//   rst_n  : synchronous active-low reset
//   bus    : ahbl_arbiter_if.slave (all src_* and dst_* signals)
// ----------------------------------------------------------------------------
module ahbl_arbiter #(
    parameter int N_PORTS = 2,
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    ahbl_arbiter_if.slave bus
);
    // Request/ownership state
    logic [N_PORTS-1:0] r_buf_valid;
    logic [N_PORTS-1:0] r_dp_owner;

    // Captured address phases
    logic [N_PORTS-1:0][W_ADDR-1:0] r_buf_haddr;
    logic [N_PORTS-1:0]             r_buf_hwrite;
    logic [N_PORTS-1:0][2:0]        r_buf_hsize;
    logic [N_PORTS-1:0][3:0]        r_buf_hprot;
    logic [N_PORTS-1:0]             r_buf_hmastlock;

    logic [N_PORTS-1:0] w_live;
    logic [N_PORTS-1:0] w_req;
    logic [N_PORTS-1:0] w_grant;
    logic               w_grant_en;
    logic               w_found;

    assign w_grant_en = bus.dst_hready_resp & rst_n;

    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            w_live[i] = bus.src_hready[i] & bus.src_htrans[i][1];
        end
    end

    assign w_req = w_live | r_buf_valid;

    // Lowest-index requester wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_grant = '0;
        w_found = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (w_req[i] && !w_found) begin
                w_grant[i] = w_grant_en;
                w_found    = 1'b1;
            end
        end
    end

    // Downstream address phase: winner's buffer if valid, else its live
    // fields. With no grant the port-0 live fields are left as don't-care.
    always_comb begin
        bus.dst_haddr     = bus.src_haddr[0];
        bus.dst_hwrite    = bus.src_hwrite[0];
        bus.dst_hsize     = bus.src_hsize[0];
        bus.dst_hprot     = bus.src_hprot[0];
        bus.dst_hmastlock = bus.src_hmastlock[0];
        bus.dst_htrans    = (|w_grant) ? 2'b10 : 2'b00;
        bus.dst_hburst    = 3'b000;
        for (int i = 0; i < N_PORTS; i++) begin
            if (w_grant[i]) begin
                if (r_buf_valid[i]) begin
                    bus.dst_haddr     = r_buf_haddr[i];
                    bus.dst_hwrite    = r_buf_hwrite[i];
                    bus.dst_hsize     = r_buf_hsize[i];
                    bus.dst_hprot     = r_buf_hprot[i];
                    bus.dst_hmastlock = r_buf_hmastlock[i];
                end else begin
                    bus.dst_haddr     = bus.src_haddr[i];
                    bus.dst_hwrite    = bus.src_hwrite[i];
                    bus.dst_hsize     = bus.src_hsize[i];
                    bus.dst_hprot     = bus.src_hprot[i];
                    bus.dst_hmastlock = bus.src_hmastlock[i];
                end
            end
        end
    end

    // Upstream responses and data-phase write data steering.
    always_comb begin
        bus.dst_hwdata = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            bus.src_hrdata[i] = bus.dst_hrdata;
            if (r_dp_owner[i]) begin
                bus.src_hready_resp[i] = bus.dst_hready_resp;
                bus.src_hresp[i]       = bus.dst_hresp;
                bus.dst_hwdata         = bus.src_hwdata[i];
            end else begin
                bus.src_hready_resp[i] = ~r_buf_valid[i];
                bus.src_hresp[i]       = 1'b0;
            end
        end
    end

    assign bus.dst_hready = bus.dst_hready_resp;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_buf_valid <= '0;
            r_dp_owner  <= '0;
        end else begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (w_grant[i]) begin
                    r_buf_valid[i] <= 1'b0;
                end else if (w_live[i]) begin
                    r_buf_valid[i] <= 1'b1;
                end
            end
            // Ownership follows the address phase accepted at this edge.
            if (bus.dst_hready_resp) begin
                r_dp_owner <= w_grant;
            end
        end
    end

    // NOTE: buffer payload has no reset; it is only read while r_buf_valid is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_PORTS; i++) begin
            if (rst_n && w_live[i] && !w_grant[i]) begin
                r_buf_haddr[i]     <= bus.src_haddr[i];
                r_buf_hwrite[i]    <= bus.src_hwrite[i];
                r_buf_hsize[i]     <= bus.src_hsize[i];
                r_buf_hprot[i]     <= bus.src_hprot[i];
                r_buf_hmastlock[i] <= bus.src_hmastlock[i];
            end
        end
    end

    // hburst is replaced by SINGLE and only htrans[1] matters for requests.
    logic w_unused;
    assign w_unused = ^{bus.src_hburst, bus.src_htrans};

endmodule

// File: tb/tb_ahbl_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ahbl_arbiter
// Directed bench for ahbl_arbiter with two masters. Inputs change on the
// falling edge, outputs are checked 1 time unit later, and state updates on
// the rising edge in between. Each master sees src_hready = src_hready_resp.
// ----------------------------------------------------------------------------
module tb_ahbl_arbiter;
    localparam int N_PORTS = 2;
    localparam int W_ADDR  = 32;
    localparam int W_DATA  = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    ahbl_arbiter_if #(.N_PORTS(N_PORTS), .W_ADDR(W_ADDR), .W_DATA(W_DATA)) bus ();

    ahbl_arbiter #(.N_PORTS(N_PORTS), .W_ADDR(W_ADDR), .W_DATA(W_DATA)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.src_hready = bus.src_hready_resp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int p, input logic [1:0] tr, input logic [31:0] a,
                       input logic wr, input logic [2:0] burst);
        bus.src_htrans[p]    = tr;
        bus.src_haddr[p]     = a;
        bus.src_hwrite[p]    = wr;
        bus.src_hburst[p]    = burst;
        bus.src_hsize[p]     = 3'b010;
        bus.src_hprot[p]     = 4'b0011;
        bus.src_hmastlock[p] = 1'b0;
    endtask

    task automatic idle(input int p);
        drv(p, 2'b00, 32'h0, 1'b0, 3'b000);
    endtask

    initial begin
        rst_n               = 1'b0;
        idle(0);
        idle(1);
        bus.src_hwdata      = '0;
        bus.dst_hready_resp = 1'b1;
        bus.dst_hresp       = 1'b0;
        bus.dst_hrdata      = '0;

        // Reset state
        @(negedge clk); #1;
        chk("rst_hready_resp", 32'(bus.src_hready_resp), 32'h3);
        chk("rst_hresp",       32'(bus.src_hresp),       32'h0);
        chk("rst_htrans",      32'(bus.dst_htrans),      32'h0);
        chk("rst_hwdata",      bus.dst_hwdata,           32'h0);
        chk("rst_dst_hready",  32'(bus.dst_hready),      32'h1);

        // Single master read, zero added latency
        @(negedge clk); rst_n = 1'b1; drv(0, 2'b10, 32'h2008_0000, 1'b0, 3'b000); #1;
        chk("t1_htrans", 32'(bus.dst_htrans), 32'h2);
        chk("t1_haddr",  bus.dst_haddr,       32'h2008_0000);
        chk("t1_hwrite", 32'(bus.dst_hwrite), 32'h0);
        chk("t1_hready_resp", 32'(bus.src_hready_resp), 32'h3);
        @(negedge clk); idle(0); bus.dst_hrdata = 32'hCAFE_0001; #1;
        chk("t1_hrdata0", bus.src_hrdata[0], 32'hCAFE_0001);
        chk("t1_dp_ready", 32'(bus.src_hready_resp), 32'h3);
        chk("t1_idle",   32'(bus.dst_htrans), 32'h0);

        // Contention: port 0 write wins, port 1 read buffered
        @(negedge clk);
        drv(0, 2'b10, 32'h2000_0000, 1'b1, 3'b000);
        drv(1, 2'b10, 32'h2000_0004, 1'b0, 3'b000); #1;
        chk("t2_haddr0",  bus.dst_haddr,       32'h2000_0000);
        chk("t2_hwrite0", 32'(bus.dst_hwrite), 32'h1);
        chk("t2_resp",    32'(bus.src_hready_resp), 32'h3);
        @(negedge clk); idle(0); idle(1); bus.src_hwdata[0] = 32'hA5A5_A5A5; #1;
        chk("t2_buf_stall", 32'(bus.src_hready_resp), 32'h1);
        chk("t2_htrans1",   32'(bus.dst_htrans), 32'h2);
        chk("t2_haddr1",    bus.dst_haddr,       32'h2000_0004);
        chk("t2_hwrite1",   32'(bus.dst_hwrite), 32'h0);
        chk("t2_hwdata",    bus.dst_hwdata,      32'hA5A5_A5A5);
        @(negedge clk); bus.src_hwdata[0] = '0; bus.dst_hrdata = 32'h0BAD_F00D; #1;
        chk("t2_resp_done", 32'(bus.src_hready_resp), 32'h3);
        chk("t2_hrdata1",   bus.src_hrdata[1], 32'h0BAD_F00D);
        chk("t2_idle",      32'(bus.dst_htrans), 32'h0);

        // Port 1 arrives while port 0's data phase is stalled 3 cycles
        @(negedge clk); drv(0, 2'b10, 32'h2000_0010, 1'b0, 3'b000); #1;
        chk("t3_haddr0", bus.dst_haddr, 32'h2000_0010);
        @(negedge clk); idle(0); drv(1, 2'b10, 32'h2000_0020, 1'b1, 3'b000);
        bus.dst_hready_resp = 1'b0; #1;
        chk("t3_stall1_resp", 32'(bus.src_hready_resp), 32'h2);
        chk("t3_stall1_idle", 32'(bus.dst_htrans), 32'h0);
        @(negedge clk); idle(1); bus.src_hwdata[1] = 32'h1234_5678; #1;
        chk("t3_stall2_resp", 32'(bus.src_hready_resp), 32'h0);
        chk("t3_stall2_idle", 32'(bus.dst_htrans), 32'h0);
        @(negedge clk); #1;
        chk("t3_stall3_resp", 32'(bus.src_hready_resp), 32'h0);
        @(negedge clk); bus.dst_hready_resp = 1'b1; bus.dst_hrdata = 32'h55AA_0010; #1;
        chk("t3_issue_resp",  32'(bus.src_hready_resp), 32'h1);
        chk("t3_issue_trans", 32'(bus.dst_htrans), 32'h2);
        chk("t3_issue_addr",  bus.dst_haddr,       32'h2000_0020);
        chk("t3_issue_write", 32'(bus.dst_hwrite), 32'h1);
        chk("t3_hrdata0",     bus.src_hrdata[0],   32'h55AA_0010);
        @(negedge clk); #1;
        chk("t3_hwdata1", bus.dst_hwdata, 32'h1234_5678);
        chk("t3_done",    32'(bus.src_hready_resp), 32'h3);

        // INCR burst on port 0, port 1 joins at beat 2
        @(negedge clk); bus.src_hwdata[1] = '0; drv(0, 2'b10, 32'h2000_0100, 1'b0, 3'b011); #1;
        chk("t4_b1_trans", 32'(bus.dst_htrans), 32'h2);
        chk("t4_b1_burst", 32'(bus.dst_hburst), 32'h0);
        @(negedge clk); drv(0, 2'b11, 32'h2000_0104, 1'b0, 3'b011);
        drv(1, 2'b10, 32'h2000_0200, 1'b0, 3'b000); #1;
        chk("t4_b2_trans", 32'(bus.dst_htrans), 32'h2);
        chk("t4_b2_addr",  bus.dst_haddr,       32'h2000_0104);
        chk("t4_b2_burst", 32'(bus.dst_hburst), 32'h0);
        @(negedge clk); drv(0, 2'b11, 32'h2000_0108, 1'b0, 3'b011); idle(1); #1;
        chk("t4_b3_addr",  bus.dst_haddr, 32'h2000_0108);
        chk("t4_b3_resp",  32'(bus.src_hready_resp), 32'h1);
        @(negedge clk); drv(0, 2'b11, 32'h2000_010C, 1'b0, 3'b011); #1;
        chk("t4_b4_addr",  bus.dst_haddr, 32'h2000_010C);
        chk("t4_b4_trans", 32'(bus.dst_htrans), 32'h2);
        @(negedge clk); idle(0); #1;
        chk("t4_p1_addr",  bus.dst_haddr, 32'h2000_0200);
        chk("t4_p1_trans", 32'(bus.dst_htrans), 32'h2);
        chk("t4_p1_resp",  32'(bus.src_hready_resp), 32'h1);
        @(negedge clk); #1;
        chk("t4_done", 32'(bus.src_hready_resp), 32'h3);

        // Two-cycle ERROR to port 1, port 0 buffered in cycle 1
        @(negedge clk); drv(1, 2'b10, 32'h2000_0300, 1'b1, 3'b000); #1;
        chk("t5_addr1", bus.dst_haddr, 32'h2000_0300);
        @(negedge clk); idle(1); bus.src_hwdata[1] = 32'hDEAD_0001;
        drv(0, 2'b10, 32'h2000_0400, 1'b0, 3'b000);
        bus.dst_hready_resp = 1'b0; bus.dst_hresp = 1'b1; #1;
        chk("t5_err1_hresp", 32'(bus.src_hresp),       32'h2);
        chk("t5_err1_resp",  32'(bus.src_hready_resp), 32'h1);
        chk("t5_err1_trans", 32'(bus.dst_htrans),      32'h0);
        @(negedge clk); idle(0); bus.dst_hready_resp = 1'b1; #1;
        chk("t5_err2_hresp", 32'(bus.src_hresp),       32'h2);
        chk("t5_err2_resp",  32'(bus.src_hready_resp), 32'h2);
        chk("t5_err2_trans", 32'(bus.dst_htrans),      32'h2);
        chk("t5_err2_addr",  bus.dst_haddr,            32'h2000_0400);
        @(negedge clk); bus.dst_hresp = 1'b0; bus.src_hwdata[1] = '0; #1;
        chk("t5_done_hresp", 32'(bus.src_hresp),       32'h0);
        chk("t5_done_resp",  32'(bus.src_hready_resp), 32'h3);

        // Reset while port 1 is buffered
        @(negedge clk); drv(0, 2'b10, 32'h2000_0500, 1'b0, 3'b000);
        drv(1, 2'b10, 32'h2000_0600, 1'b0, 3'b000); #1;
        chk("t6_addr0", bus.dst_haddr, 32'h2000_0500);
        @(negedge clk); idle(0); idle(1); bus.dst_hready_resp = 1'b0; #1;
        chk("t6_held", 32'(bus.src_hready_resp), 32'h0);
        @(negedge clk); rst_n = 1'b0; bus.dst_hready_resp = 1'b1;
        drv(0, 2'b10, 32'h2000_0700, 1'b0, 3'b000); #1;
        chk("t6_rst_no_grant", 32'(bus.dst_htrans), 32'h0);
        chk("t6_pre_edge",     32'(bus.src_hready_resp), 32'h1);
        @(negedge clk); #1;
        chk("t6_rst_resp",   32'(bus.src_hready_resp), 32'h3);
        chk("t6_rst_trans",  32'(bus.dst_htrans),      32'h0);
        chk("t6_rst_hresp",  32'(bus.src_hresp),       32'h0);
        chk("t6_rst_hwdata", bus.dst_hwdata,           32'h0);
        @(negedge clk); rst_n = 1'b1; idle(0); #1;
        chk("t6_buf_gone",  32'(bus.dst_htrans),      32'h0);
        chk("t6_after_rst", 32'(bus.src_hready_resp), 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
